uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of byte requesters (2..8).
REQ-002 The block SHALL have parameter DBIT, default 8, meaning the data bits per frame, matching the transmitter.
REQ-003 The block SHALL have parameter TIMEOUT, default 100000, meaning the clk cycles allowed for tx_done_tick after launch.
REQ-004 The block SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid  input  NREQ  per-requester byte-pending flag, held until accepted.
REQ-007 The block SHALL have port req_data  input  NREQ*DBIT  requester i byte at bits [i*DBIT +: DBIT].
REQ-008 The block SHALL have port req_ready  output  NREQ  one-cycle accept pulse to the granted requester.
REQ-009 The block SHALL have port tx_din  output  DBIT  byte to transmitter din, registered.
REQ-010 The block SHALL have port tx_en  output  1  one-cycle transmit-start pulse to transmitter.
REQ-011 The block SHALL have port tx_done_tick  input  1  transmitter frame-complete pulse.
REQ-012 The block SHALL have port grant_id  output  clog2(NREQ)  index of the requester owning the current or last frame.
REQ-013 The block SHALL have port busy  output  1  high in START and WAIT.
REQ-014 The block SHALL have port timeout_err  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, START, and WAIT.
REQ-016 In IDLE with any req_valid high, the block SHALL select a winner by round-robin, starting the search at (last_grant+1) mod NREQ and ascending with wrap.
REQ-017 The IDLE->START edge SHALL register tx_din <= winner data, grant_id <= winner, and last_grant <= winner.
REQ-018 In START (one cycle), tx_en SHALL be 1 and req_ready[grant_id] SHALL be 1; all other req_ready bits SHALL be 0; the next state SHALL be WAIT.
REQ-019 The launch latency SHALL be exactly one cycle from IDLE sampling a valid request to tx_en/req_ready high.
REQ-020 Requesters SHALL drop or update req_valid/req_data in the cycle after their req_ready pulse; the block SHALL NOT re-sample req_valid until IDLE.
REQ-021 In WAIT, tx_done_tick=1 SHALL move the FSM to IDLE on the next edge; the minimum gap between consecutive tx_en pulses SHALL therefore be frame time plus 1 IDLE cycle.
REQ-022 tx_done_tick SHALL be ignored in IDLE and START.
REQ-023 The watchdog counter SHALL clear on entering WAIT and increment each WAIT cycle; the counter width SHALL be clog2(TIMEOUT+1).
REQ-024 If the watchdog count reaches TIMEOUT-1 with tx_done_tick low, the block SHALL pulse timeout_err for one cycle and go to IDLE, keeping last_grant advanced so the failed requester is not re-favoured.
REQ-025 If tx_done_tick and expiry coincide, tx_done_tick SHALL win and no timeout_err SHALL be raised.
REQ-026 The block SHALL keep tx_din stable from START until the next IDLE->START edge.
REQ-027 A req_valid deasserted before grant SHALL be dropped silently, with no req_ready pulse.
REQ-028 When all req_valid bits are low, the block SHALL stay in IDLE with tx_en=0.

Reset
REQ-029 Reset low SHALL immediately force state=IDLE, tx_en=0, req_ready=0, busy=0, timeout_err=0, tx_din=0, grant_id=0, last_grant=NREQ-1 (requester 0 first), watchdog=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no req_ready or timeout_err pulse; the transmitter SHALL be reset by the same reset.
REQ-031 Reset deassertion SHALL take effect on the next rising clk edge.

Verification
REQ-032 The bench SHALL cover: single request, req_valid[2]=1 with byte 0x39 -> tx_en and req_ready[2] high one cycle later, tx_din=0x39, grant_id=2, busy until the cycle after tx_done_tick.
REQ-033 The bench SHALL cover: simultaneous requests, all 4 valid with bytes 0xA0..0xA3 held until served -> grant order 0,1,2,3, serial line carries 0xA0,0xA1,0xA2,0xA3.
REQ-034 The bench SHALL cover: fairness, req 0 and 3 continuously re-asserted -> grants alternate 0,3,0,3; requester 0 is never served twice in a row.
REQ-035 The bench SHALL cover: watchdog, with TIMEOUT=50 and tx_done_tick forced low -> timeout_err pulses exactly 50 cycles after entering WAIT, FSM returns to IDLE, and the next grant goes to the next requester.
REQ-036 The bench SHALL cover: reset mid-frame, reset low during WAIT -> all outputs at reset values asynchronously, no req_ready; after release, requester 0 has first priority.
REQ-037 The bench SHALL cover: coincidence, tx_done_tick on the expiry cycle -> no timeout_err, normal return to IDLE.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that feeds one requester byte at a time to a UART transmitter,
// with a watchdog that abandons a frame whose done tick never arrives.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DBIT    = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DBIT-1:0]    req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [DBIT-1:0]         tx_din,
    output logic                    tx_en,
    input  logic                    tx_done_tick,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    timeout_err
);
    localparam int GW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t        state, state_nx;
    logic [GW-1:0] last_grant, winner, cand;
    logic [WW-1:0] wdog;
    logic          expire;

    // Scan offsets from farthest to nearest so the requester right after last_grant wins.
    always_comb begin
        winner = last_grant;
        cand   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = GW'((int'(last_grant) + i) % NREQ);
            winner = req_valid[cand] ? cand : winner;
        end
    end

    // A done tick on the expiry cycle takes precedence over the watchdog.
    assign expire = state == WAIT && !tx_done_tick && wdog == WW'(TIMEOUT - 1);

    always_comb begin
        state_nx = state == IDLE  ? (|req_valid ? START : IDLE) :
                   state == START ? WAIT :
                   (tx_done_tick || expire) ? IDLE : WAIT;
    end

    assign tx_en     = state == START;
    assign busy      = state != IDLE;
    assign req_ready = tx_en ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_id) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tx_din      <= '0;
            grant_id    <= '0;
            last_grant  <= GW'(NREQ - 1);
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            timeout_err <= expire;
            wdog        <= state == WAIT ? wdog + 1'b1 : '0;
            if (state == IDLE && |req_valid) begin
                tx_din     <= req_data[winner*DBIT +: DBIT];
                grant_id   <= winner;
                last_grant <= winner;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a behavioural UART transmitter and serial-line receiver.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4, DBIT = 8, TIMEOUT = 50, BT = 2;

    logic clk = 0, reset = 1;
    logic [NREQ-1:0] req_valid = '0, req_ready;
    logic [NREQ*DBIT-1:0] req_data = '0;
    logic [DBIT-1:0] tx_din;
    logic tx_en, tx_done_tick, busy, timeout_err;
    logic [1:0] grant_id;
    int n_tests = 0, n_fail = 0;

    typedef struct packed {logic [1:0] id; logic [7:0] data;} exp_t;
    exp_t exp_q[$];
    logic [7:0] ser_q[$], rx_q[$];
    logic [3:0] keep = '0;
    logic done_inhibit = 0, manual_done = 0, model_done;

    uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_din(tx_din), .tx_en(tx_en), .tx_done_tick(tx_done_tick),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Transmitter: start bit, DBIT data bits LSB first, stop bit, BT clocks per bit.
    logic active, tx_line;
    int cnt;
    logic [DBIT+1:0] frame;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= 0; cnt <= 0; tx_line <= 1; model_done <= 0; frame <= '0;
        end else begin
            model_done <= 0;
            if (!active && tx_en) begin
                frame <= {1'b1, tx_din, 1'b0}; active <= 1; cnt <= 0;
            end else if (active) begin
                tx_line <= frame[cnt/BT];
                cnt <= cnt + 1;
                if (cnt == (DBIT + 2) * BT - 1) begin active <= 0; model_done <= 1; end
            end
        end
    end
    assign tx_done_tick = (model_done && !done_inhibit) || manual_done;

    // Receiver on the serial line.
    logic rx_on;
    int rx_cnt;
    logic [DBIT-1:0] rx_sh;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_on <= 0; rx_cnt <= 0; rx_sh <= '0;
        end else if (!rx_on) begin
            if (!tx_line) begin rx_on <= 1; rx_cnt <= 1; end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt <= BT * DBIT && rx_cnt % BT == 0) rx_sh <= {tx_line, rx_sh[DBIT-1:1]};
            if (rx_cnt == BT * (DBIT + 1)) begin rx_on <= 0; rx_q.push_back(rx_sh); end
        end
    end

    task automatic serve_one(output bit seen, output logic [1:0] gid, output logic [7:0] din,
                             output logic [3:0] rdy, output int lat);
        seen = 0; lat = 0; gid = '0; din = '0; rdy = '0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            if (tx_en) begin
                seen = 1; gid = grant_id; din = tx_din; rdy = req_ready;
                if (!keep[grant_id]) req_valid[grant_id] = 0;
                else req_data[grant_id*DBIT +: DBIT] = req_data[grant_id*DBIT +: DBIT] + 8'd1;
            end
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || active) && k < 300) begin @(negedge clk); k++; end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle: busy=%b after %0d cycles, expected 0", busy, k);
        end
    endtask

    task automatic test_reset();
        #2 reset = 0;
        #1;
        n_tests++;
        if ({tx_en, req_ready, busy, timeout_err, tx_din, grant_id} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_values: en=%b rdy=%b busy=%b terr=%b din=%h gid=%0d, expected all 0",
                     tx_en, req_ready, busy, timeout_err, tx_din, grant_id);
        end
        repeat (3) @(negedge clk);
        reset = 1;
    endtask

    task automatic test_simultaneous();
        bit seen; logic [1:0] gid; logic [7:0] din, got, want; logic [3:0] rdy; int lat; exp_t e;
        wait_idle();
        rx_q.delete();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_valid = 4'hF;
        keep = 4'h0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{id: 2'(i), data: 8'hA0 + 8'(i)});
            ser_q.push_back(8'hA0 + 8'(i));
        end
        for (int i = 0; i < 4; i++) begin
            serve_one(seen, gid, din, rdy, lat);
            e = exp_q.pop_front();
            n_tests++;
            if (!seen || gid !== e.id || din !== e.data || rdy !== (4'b0001 << e.id)) begin
                n_fail++;
                $display("FAIL simultaneous launch: seen=%0b id=%0d din=%h ready=%b, expected id=%0d din=%h ready=%b",
                         seen, gid, din, rdy, e.id, e.data, 4'b0001 << e.id);
            end
        end
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            got = rx_q.size() > 0 ? rx_q.pop_front() : 8'hxx;
            want = ser_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL simultaneous serial: byte %0d got %h, expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_fairness();
        bit seen; logic [1:0] gid, prev; logic [7:0] din; logic [3:0] rdy; int lat; exp_t e;
        wait_idle();
        req_data[0 +: 8] = 8'h50;
        req_data[24 +: 8] = 8'h80;
        keep = 4'b1001;
        req_valid = 4'b1001;
        exp_q.push_back('{id: 2'd0, data: 8'h50});
        exp_q.push_back('{id: 2'd3, data: 8'h80});
        exp_q.push_back('{id: 2'd0, data: 8'h51});
        exp_q.push_back('{id: 2'd3, data: 8'h81});
        prev = 2'd3;
        for (int i = 0; i < 4; i++) begin
            serve_one(seen, gid, din, rdy, lat);
            if (i == 3) begin req_valid = 4'b0000; keep = 4'b0000; end
            e = exp_q.pop_front();
            n_tests++;
            if (!seen || gid !== e.id || din !== e.data || rdy !== (4'b0001 << e.id)) begin
                n_fail++;
                $display("FAIL fairness launch: seen=%0b id=%0d din=%h ready=%b, expected id=%0d din=%h ready=%b",
                         seen, gid, din, rdy, e.id, e.data, 4'b0001 << e.id);
            end
            n_tests++;
            if (gid == 2'd0 && prev == 2'd0) begin
                n_fail++;
                $display("FAIL fairness repeat: requester 0 granted twice in a row at grant %0d", i);
            end
            prev = gid;
        end
        wait_idle();
    endtask

    task automatic test_single();
        bit seen, done_seen; logic [1:0] gid; logic [7:0] din, got; logic [3:0] rdy; int lat; exp_t e;
        wait_idle();
        rx_q.delete();
        req_data[16 +: 8] = 8'h39;
        req_valid = 4'b0100;
        exp_q.push_back('{id: 2'd2, data: 8'h39});
        serve_one(seen, gid, din, rdy, lat);
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || gid !== e.id || din !== e.data || rdy !== (4'b0001 << e.id)) begin
            n_fail++;
            $display("FAIL single launch: seen=%0b id=%0d din=%h ready=%b, expected id=%0d din=%h ready=%b",
                     seen, gid, din, rdy, e.id, e.data, 4'b0001 << e.id);
        end
        n_tests++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL single latency: %0d cycles, expected 1", lat);
        end
        done_seen = 0;
        for (int k = 0; k < 100 && !done_seen; k++) begin
            @(negedge clk);
            done_seen = tx_done_tick;
        end
        n_tests++;
        if (!done_seen || busy !== 1'b1 || tx_din !== 8'h39) begin
            n_fail++;
            $display("FAIL single wait: done=%b busy=%b din=%h, expected done=1 busy=1 din=39", done_seen, busy, tx_din);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || tx_en !== 1'b0) begin
            n_fail++;
            $display("FAIL single release: busy=%b en=%b after done, expected 0 0", busy, tx_en);
        end
        wait_idle();
        got = rx_q.size() > 0 ? rx_q.pop_front() : 8'hxx;
        n_tests++;
        if (got !== 8'h39) begin
            n_fail++;
            $display("FAIL single serial: got %h, expected 39", got);
        end
    endtask

    task automatic test_watchdog();
        bit seen; logic [1:0] gid; logic [7:0] din; logic [3:0] rdy; int lat, first; exp_t e;
        wait_idle();
        done_inhibit = 1;
        req_data[24 +: 8] = 8'hC3;
        req_data[0 +: 8] = 8'hC0;
        keep = 4'b1001;
        req_valid = 4'b1001;
        exp_q.push_back('{id: 2'd3, data: 8'hC3});
        exp_q.push_back('{id: 2'd0, data: 8'hC0});
        serve_one(seen, gid, din, rdy, lat);
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || gid !== e.id || din !== e.data || rdy !== (4'b0001 << e.id)) begin
            n_fail++;
            $display("FAIL watchdog launch: seen=%0b id=%0d din=%h ready=%b, expected id=%0d din=%h ready=%b",
                     seen, gid, din, rdy, e.id, e.data, 4'b0001 << e.id);
        end
        first = 0;
        for (int k = 1; k <= 51; k++) begin
            @(negedge clk);
            if (timeout_err && first == 0) first = k;
        end
        n_tests++;
        if (first !== 51 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL watchdog expiry: timeout_err first at %0d busy=%b, expected 51 busy=0", first, busy);
        end
        done_inhibit = 0;
        keep = 4'b0000;
        serve_one(seen, gid, din, rdy, lat);
        req_valid = 4'b0000;
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || gid !== e.id || din !== e.data || rdy !== (4'b0001 << e.id)) begin
            n_fail++;
            $display("FAIL watchdog next_grant: seen=%0b id=%0d din=%h ready=%b, expected id=%0d din=%h ready=%b",
                     seen, gid, din, rdy, e.id, e.data, 4'b0001 << e.id);
        end
        n_tests++;
        if (timeout_err !== 1'b0 || lat !== 1) begin
            n_fail++;
            $display("FAIL watchdog pulse: timeout_err=%b lat=%0d on relaunch, expected 0 and 1", timeout_err, lat);
        end
        wait_idle();
    endtask

    task automatic test_coincidence();
        bit seen, err_seen; logic [1:0] gid; logic [7:0] din; logic [3:0] rdy; int lat; logic busy51; exp_t e;
        wait_idle();
        done_inhibit = 1;
        req_data[8 +: 8] = 8'h5A;
        req_valid = 4'b0010;
        exp_q.push_back('{id: 2'd1, data: 8'h5A});
        serve_one(seen, gid, din, rdy, lat);
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || gid !== e.id || din !== e.data || rdy !== (4'b0001 << e.id)) begin
            n_fail++;
            $display("FAIL coincidence launch: seen=%0b id=%0d din=%h ready=%b, expected id=%0d din=%h ready=%b",
                     seen, gid, din, rdy, e.id, e.data, 4'b0001 << e.id);
        end
        err_seen = 0;
        busy51 = 1'bx;
        for (int k = 1; k <= 53; k++) begin
            @(negedge clk);
            if (timeout_err) err_seen = 1;
            if (k == 51) busy51 = busy;
            manual_done = (k == 50);
        end
        manual_done = 0;
        n_tests++;
        if (err_seen !== 1'b0 || busy51 !== 1'b0) begin
            n_fail++;
            $display("FAIL coincidence: timeout_err seen=%b busy=%b after done, expected 0 0", err_seen, busy51);
        end
        done_inhibit = 0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        bit seen, bad; logic [1:0] gid; logic [7:0] din; logic [3:0] rdy; int lat; exp_t e;
        wait_idle();
        req_data[16 +: 8] = 8'h77;
        req_valid = 4'b0100;
        exp_q.push_back('{id: 2'd2, data: 8'h77});
        serve_one(seen, gid, din, rdy, lat);
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || gid !== e.id || din !== e.data || rdy !== (4'b0001 << e.id)) begin
            n_fail++;
            $display("FAIL reset_mid launch: seen=%0b id=%0d din=%h ready=%b, expected id=%0d din=%h ready=%b",
                     seen, gid, din, rdy, e.id, e.data, 4'b0001 << e.id);
        end
        repeat (5) @(negedge clk);
        req_valid = 4'b1010;
        #2 reset = 0;
        #1;
        n_tests++;
        if ({tx_en, req_ready, busy, timeout_err, tx_din, grant_id} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_mid async: en=%b rdy=%b busy=%b terr=%b din=%h gid=%0d, expected all 0",
                     tx_en, req_ready, busy, timeout_err, tx_din, grant_id);
        end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (req_ready !== 4'b0 || timeout_err !== 1'b0 || tx_en !== 1'b0) bad = 1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_mid hold: req_ready/timeout_err/tx_en pulsed during reset, expected none");
        end
        req_data = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
        req_valid = 4'hF;
        reset = 1;
        exp_q.push_back('{id: 2'd0, data: 8'hE0});
        serve_one(seen, gid, din, rdy, lat);
        req_valid = 4'h0;
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || gid !== e.id || din !== e.data || rdy !== (4'b0001 << e.id) || lat !== 1) begin
            n_fail++;
            $display("FAIL reset_mid priority: seen=%0b id=%0d din=%h ready=%b lat=%0d, expected id=%0d din=%h ready=%b lat=1",
                     seen, gid, din, rdy, lat, e.id, e.data, 4'b0001 << e.id);
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_fairness();
        test_single();
        test_watchdog();
        test_coincidence();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
